// File: rtl/tick_gen_multi.sv
// tick_gen_multi
//   Multi-channel ripple-carry tick generator. Each channel counts from 0 up to
//   its own terminal count (div). It then emits a single-cycle rco pulse that
//   downstream logic uses as a clock enable. A channel runs either
//   periodically or as a retriggerable one-shot. A global enable pauses every
//   channel.
//
// Ports
//   mclk     in   system clock, all state updates on the rising edge
//   reset    in   synchronous active-high reset
//   en       in   global count enable; low freezes every channel, forces rco=0
//   wr_en    in   configuration write strobe
//   wr_ch    in   channel index for the write (out-of-range index ignored)
//   wr_div   in   new terminal count
//   wr_mode  in   new mode: 0 = periodic, 1 = one-shot
//   start    in   per-channel arm/restart strobe (one-shot channels only)
//   rco      out  per-channel single-cycle terminal-count pulse
//   busy     out  per-channel one-shot-armed flag
module tick_gen_multi #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DEFAULT_DIV = 10000,
    parameter int unsigned CH_W        = 4
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic                wr_mode,
    input  logic [CHANNELS-1:0] start,
    output logic [CHANNELS-1:0] rco,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [WIDTH-1:0] DefaultDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;    // 1 = one-shot
    logic [CHANNELS-1:0] armed_q, armed_d;

    assign busy = armed_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            logic tc;
            tc = (cnt_q[i] == div_q[i]);

            // Pure decode of registered state: no added latency on the pulse.
            rco[i] = en & tc & (~mode_q[i] | armed_q[i]);

            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            mode_d[i]  = mode_q[i];
            armed_d[i] = armed_q[i];

            if (wr_en && (wr_ch == CH_W'(i))) begin
                // A write reconfigures and clears the channel; a start in the
                // same cycle then arms it against the new configuration.
                div_d[i]   = wr_div;
                mode_d[i]  = wr_mode;
                cnt_d[i]   = '0;
                armed_d[i] = start[i] & wr_mode;
            end else if (start[i] && mode_q[i]) begin
                // Arm, or retrigger an in-flight run from zero.
                armed_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end else if (en) begin
                if (!mode_q[i]) begin
                    cnt_d[i] = tc ? '0 : cnt_q[i] + WIDTH'(1);
                end else if (armed_q[i]) begin
                    if (tc) begin
                        armed_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DefaultDiv;
            end
            mode_q  <= '0;
            armed_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised multi-channel successor to the single fixed-count 1 s RCO tick generator.
- Provides CHANNELS independent counters, each with a runtime-programmable terminal count and a periodic or one-shot mode.
- Each channel emits a single-cycle ripple-carry pulse used as a clock-enable by downstream timing logic (display refresh, debounce, seconds base).
- Includes a global enable for pausing all channels.

Parameters:
- WIDTH, 16, counter and terminal-count width in bits.
- CHANNELS, 4, number of independent channels (1..16).
- DEFAULT_DIV, 10000, terminal count loaded into every channel at reset (must fit in WIDTH).
- CH_W, 4, width of channel select; must satisfy 2**CH_W >= CHANNELS.

Ports:
- mclk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global count enable; low freezes all channels.
- wr_en  in  1  write strobe for per-channel configuration.
- wr_ch  in  CH_W  channel index for the write.
- wr_div  in  WIDTH  new terminal count.
- wr_mode  in  1  0 = periodic, 1 = one-shot.
- start  in  CHANNELS  per-channel arm/restart strobe (meaningful in one-shot mode only).
- rco  out  CHANNELS  per-channel single-cycle terminal-count pulse.
- busy  out  CHANNELS  per-channel one-shot-armed flag (0 for periodic channels).

Behaviour:
- Per-channel state: cnt[WIDTH], div[WIDTH], mode, armed.
- Reset (reset=1 at a rising edge of mclk): cnt=0, div=DEFAULT_DIV, mode=periodic, armed=0 for every channel. rco=0 and busy=0 from the next cycle. Reset overrides wr_en, start and en.
- rco[i] = en & (cnt[i]==div[i]) & (mode[i]==periodic | armed[i]). It is a combinational decode of registered state and en; there is no extra latency.
- busy[i] = armed[i].
- Periodic mode, en=1:
  - cnt increments each cycle.
  - When cnt==div, cnt wraps to 0 on the next edge.
  - Period is div+1 cycles with exactly one rco cycle per period.
  - div=0 gives rco high on every enabled cycle.
- One-shot mode:
  - Idle while armed=0: cnt held at 0, rco=0.
  - start[i]=1 sets armed and clears cnt to 0.
  - While armed and en=1, cnt increments.
  - At cnt==div, rco pulses for one cycle; armed clears and cnt returns to 0 on the next edge.
  - First rco occurs div+1 cycles after the start edge.
  - start while armed restarts the count from 0 (retrigger) with no rco for the aborted run.
- en=0: all cnt and armed values hold, all rco=0. Resuming with en=1 continues from the held cnt.
- Configuration write (wr_en=1, wr_ch<CHANNELS):
  - On the next edge, div and mode of that channel take the new values, cnt clears to 0 and armed clears.
  - Other channels are unaffected.
  - wr_ch>=CHANNELS: write ignored, no state change.
- Simultaneous write and start on the same channel: write applies first, then start arms with the new div/mode. Net result: armed=1 if the new mode is one-shot, cnt=0.
- Reducing div below the current cnt is impossible, because a write always clears cnt.
- Counter arithmetic is modulo 2**WIDTH unsigned. cnt never exceeds div during normal operation.
- Channels operate fully independently; multiple rco bits may be high in the same cycle.

Test Plan:
- Reset then en=1 for 30005 cycles, CHANNELS=4 -> rco[0..3] each high at cycles 10000, 20001, 30002 after reset release (period 10001); busy=0 throughout.
- Write ch1 div=3 periodic, en=1 -> rco[1] high every 4th cycle starting 3 cycles after the write edge; ch0 timing unchanged. Then write ch2 div=0 -> rco[2] continuously high.
- Write ch3 div=5 one-shot, pulse start[3] -> busy[3]=1 for 6 cycles, a single rco[3] pulse on the 6th cycle, then busy=0. No further pulses after 50 cycles.
- One-shot ch3 div=5: start, 3 cycles later start again -> rco[3] occurs 6 cycles after the second start only. Drop en for 10 cycles mid-run -> pulse delayed exactly 10 cycles.
- Same-cycle wr_en(ch0, div=2, one-shot) plus start[0] -> busy[0]=1, rco[0] after 3 cycles. Write with wr_ch=7 (CHANNELS=4) -> no state change.
- Assert reset mid one-shot run and mid periodic count -> next cycle all cnt=0, div=10000, busy=0, rco=0, even with wr_en/start asserted.
